// File: rtl/expr_pipe_eval_if.sv
// Handshake bundle for expr_pipe_eval: operand beat in, result beat out.
// Includes the sticky overflow flags and their clear strobe.
interface expr_pipe_eval_if #(
  parameter int W   = 6,
  parameter int NCH = 3
);
  logic                   in_valid;
  logic                   in_ready;
  logic [NCH*W-1:0]       a;
  logic [NCH*W-1:0]       b;
  logic [NCH*3-1:0]       op;
  logic [NCH-1:0]         sgn;
  logic                   out_valid;
  logic                   out_ready;
  logic [NCH*(W+1)-1:0]   y;
  logic [NCH-1:0]         ovf;
  logic                   clr_ovf;

  modport master (
    output in_valid, a, b, op, sgn,
    output out_ready, clr_ovf,
    input  in_ready, out_valid, y, ovf
  );

  modport slave (
    input  in_valid, a, b, op, sgn,
    input  out_ready, clr_ovf,
    output in_ready, out_valid, y, ovf
  );
endinterface

// File: rtl/expr_pipe_eval.sv
// Two-stage pipelined multi-channel expression evaluator.
// S1 holds operands, S2 holds the W+1-bit results per channel.
module expr_pipe_eval #(
  parameter int W   = 6,
  parameter int NCH = 3
) (
  input  logic clk,
  input  logic rst,
  expr_pipe_eval_if.slave bus
);
  localparam int SW = $clog2(W) + 1;
  localparam int YW = NCH * (W + 1);
  localparam logic [SW-1:0] WLIM = SW'(W);

  typedef enum logic [2:0] {
    OP_ADD = 3'd0,
    OP_SUB = 3'd1,
    OP_AND = 3'd2,
    OP_XOR = 3'd3,
    OP_SHL = 3'd4,
    OP_SHR = 3'd5,
    OP_LT  = 3'd6,
    OP_NE  = 3'd7
  } op_e;

  typedef struct packed {
    logic [NCH*W-1:0] a;
    logic [NCH*W-1:0] b;
    logic [NCH*3-1:0] op;
    logic [NCH-1:0]   sgn;
  } s1_t;

  function automatic logic [W:0] eval(
    input logic [W-1:0] x,
    input logic [W-1:0] z,
    input logic [2:0]   o,
    input logic         s
  );
    logic [W:0]    xe;
    logic [W:0]    ze;
    logic [W:0]    r;
    logic [W-1:0]  t;
    logic [SW-1:0] sh;
    logic          big;
    xe  = {s & x[W-1], x};
    ze  = {s & z[W-1], z};
    sh  = z[SW-1:0];
    big = (sh >= WLIM);
    t   = '0;
    r   = '0;
    unique case (o)
      OP_ADD: r = xe + ze;
      OP_SUB: r = xe - ze;
      OP_AND: r = xe & ze;
      OP_XOR: r = xe ^ ze;
      OP_SHL: begin
        if (big) t = '0;
        else     t = x << sh;
        r = {s & t[W-1], t};
      end
      OP_SHR: begin
        // keep the signed shift out of mixed-sign expressions
        if (big)    t = {W{s & x[W-1]}};
        else if (s) t = $signed(x) >>> sh;
        else        t = x >> sh;
        r = {s & t[W-1], t};
      end
      OP_LT: begin
        if (s) r = {{W{1'b0}}, $signed(x) < $signed(z)};
        else   r = {{W{1'b0}}, x < z};
      end
      OP_NE:   r = {{W{1'b0}}, x != z};
      default: r = '0;
    endcase
    return r;
  endfunction

  logic           s1_valid;
  logic           s2_valid;
  logic           s1_load;
  logic           s2_load;
  s1_t            s1;
  logic [YW-1:0]  y_d;
  logic [YW-1:0]  y_q;
  logic [NCH-1:0] ovf_set;
  logic [NCH-1:0] ovf_q;

  assign s2_load = !s2_valid || bus.out_ready;
  assign s1_load = !s1_valid || s2_load;

  assign bus.in_ready  = s1_load;
  assign bus.out_valid = s2_valid;
  assign bus.y         = y_q;
  assign bus.ovf       = ovf_q;

  for (genvar c = 0; c < NCH; c++) begin : g_ch
    logic [W:0] r;
    logic [2:0] o;
    logic       addsub;
    assign o      = s1.op[c*3 +: 3];
    assign addsub = (o == OP_ADD) || (o == OP_SUB);
    assign r      = eval(s1.a[c*W +: W], s1.b[c*W +: W], o, s1.sgn[c]);
    assign y_d[c*(W+1) +: W+1] = r;
    // top two bits differ => result does not fit W signed bits
    assign ovf_set[c] = s1_valid & s2_load & s1.sgn[c] &
                        addsub & (r[W] ^ r[W-1]);
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      s1_valid <= 1'b0;
      s1       <= '0;
    end else if (s1_load) begin
      s1_valid <= bus.in_valid;
      if (bus.in_valid) begin
        s1 <= '{a: bus.a, b: bus.b, op: bus.op, sgn: bus.sgn};
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      s2_valid <= 1'b0;
      y_q      <= '0;
    end else if (s2_load) begin
      s2_valid <= s1_valid;
      if (s1_valid) y_q <= y_d;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) ovf_q <= '0;
    else     ovf_q <= (ovf_q & ~{NCH{bus.clr_ovf}}) | ovf_set;
  end
endmodule
